// File: rtl/pipe_fwd_chain_if.sv
// rtl/pipe_fwd_chain_if.sv - ID-stage issue/lookup bundle for pipe_fwd_chain (PIPE_FWD_PERF_CNT_EN adds counters)
interface pipe_fwd_chain_if #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int SELW   = $clog2(STAGES + 1),
  parameter int RSW    = $clog2(STAGES)
);
  logic                     i_issueValid;
  logic [4:0]               i_issueRd;
  logic                     i_issueRegWrite;
  logic [RSW-1:0]           i_issueReadyStage;
  logic [4:0]               i_rs1;
  logic [4:0]               i_rs2;
  logic                     i_rs1Used;
  logic                     i_rs2Used;
  logic                     i_flush;
  logic [STAGES*XLEN-1:0]   i_stageResult;
  logic                     o_stall;
  logic [SELW-1:0]          o_fwd1Sel;
  logic [SELW-1:0]          o_fwd2Sel;
  logic [XLEN-1:0]          o_fwd1Data;
  logic [XLEN-1:0]          o_fwd2Data;
  logic                     o_retireValid;
  logic [4:0]               o_retireRd;
`ifdef PIPE_FWD_PERF_CNT_EN
  logic [31:0]              o_stallCnt;
  logic [31:0]              o_fwdCnt;
`endif

  modport master (
    output i_issueValid, i_issueRd, i_issueRegWrite, i_issueReadyStage,
    output i_rs1, i_rs2, i_rs1Used, i_rs2Used, i_flush, i_stageResult,
`ifdef PIPE_FWD_PERF_CNT_EN
    input  o_stallCnt, o_fwdCnt,
`endif
    input  o_stall, o_fwd1Sel, o_fwd2Sel, o_fwd1Data, o_fwd2Data,
    input  o_retireValid, o_retireRd
  );

  modport slave (
    input  i_issueValid, i_issueRd, i_issueRegWrite, i_issueReadyStage,
    input  i_rs1, i_rs2, i_rs1Used, i_rs2Used, i_flush, i_stageResult,
`ifdef PIPE_FWD_PERF_CNT_EN
    output o_stallCnt, o_fwdCnt,
`endif
    output o_stall, o_fwd1Sel, o_fwd2Sel, o_fwd1Data, o_fwd2Data,
    output o_retireValid, o_retireRd
  );
endinterface

// File: rtl/pipe_fwd_chain.sv
// rtl/pipe_fwd_chain.sv - in-flight writer tracking and operand bypass (PIPE_FWD_PERF_CNT_EN adds counters)
module pipe_fwd_chain #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int SELW   = $clog2(STAGES + 1),
  parameter int RSW    = $clog2(STAGES)
) (
  input  logic             clk,
  input  logic             reset_x,
  pipe_fwd_chain_if.slave  bus
);
  localparam int LAST = STAGES - 1;

  logic                   st_valid [STAGES];
  logic [4:0]             st_rd    [STAGES];
  logic                   st_rw    [STAGES];
  logic [RSW-1:0]         st_rdy   [STAGES];

  logic [STAGES*XLEN-1:0] stage_result;
  logic [4:0]             src_rs    [2];
  logic                   src_used  [2];
  logic                   src_stall [2];
  logic [SELW-1:0]        src_sel   [2];
  logic [XLEN-1:0]        src_data  [2];
  logic                   stall;
  logic                   load0;
  logic [RSW-1:0]         issue_rdy;

  assign stage_result = bus.i_stageResult;
  assign src_rs[0]    = bus.i_rs1;
  assign src_rs[1]    = bus.i_rs2;
  assign src_used[0]  = bus.i_rs1Used;
  assign src_used[1]  = bus.i_rs2Used;

  // Per source, scan oldest to youngest so the youngest matching writer is the last one assigned.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_stall[s] = 1'b0;
      src_sel[s]   = '0;
      src_data[s]  = '0;
      if (src_used[s] && src_rs[s] != 5'd0) begin
        for (int k = STAGES - 1; k >= 0; k--) begin
          if (st_valid[k] && st_rw[k] && st_rd[k] == src_rs[s]) begin
            src_sel[s]   = SELW'(k + 1);
            src_data[s]  = stage_result[k*XLEN +: XLEN];
            src_stall[s] = ({1'b0, st_rdy[k]} > (RSW+1)'(k));
          end
        end
      end
    end
  end

  // A killed or empty ID slot never holds the front end.
  assign stall = (src_stall[0] | src_stall[1]) & bus.i_issueValid & ~bus.i_flush;
  assign load0 = bus.i_issueValid & ~stall & ~bus.i_flush;

  // Out-of-range ready stages collapse onto the last tracked stage.
  always_comb begin
    issue_rdy = bus.i_issueReadyStage;
    if ({1'b0, bus.i_issueReadyStage} > (RSW+1)'(LAST))
      issue_rdy = RSW'(LAST);
  end

  // Shift register of writer records; stage 0 takes the issue or a bubble.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k] <= 1'b0;
        st_rd[k]    <= 5'd0;
        st_rw[k]    <= 1'b0;
        st_rdy[k]   <= '0;
      end
    end else begin
      if (load0) begin
        st_valid[0] <= 1'b1;
        st_rd[0]    <= bus.i_issueRd;
        st_rw[0]    <= bus.i_issueRegWrite;
        st_rdy[0]   <= issue_rdy;
      end else begin
        st_valid[0] <= 1'b0;
        st_rd[0]    <= 5'd0;
        st_rw[0]    <= 1'b0;
        st_rdy[0]   <= '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_rd[k]    <= st_rd[k-1];
        st_rw[k]    <= st_rw[k-1];
        st_rdy[k]   <= st_rdy[k-1];
      end
    end
  end

  assign bus.o_stall       = stall;
  assign bus.o_fwd1Sel     = src_sel[0];
  assign bus.o_fwd2Sel     = src_sel[1];
  assign bus.o_fwd1Data    = src_data[0];
  assign bus.o_fwd2Data    = src_data[1];
  assign bus.o_retireValid = st_valid[LAST] & st_rw[LAST];
  assign bus.o_retireRd    = st_rd[LAST];

`ifdef PIPE_FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  logic [1:0]  fwd_inc;

  assign fwd_inc = {1'b0, (src_sel[0] != '0) & ~src_stall[0]}
                 + {1'b0, (src_sel[1] != '0) & ~src_stall[1]};

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      stall_cnt <= 32'd0;
      fwd_cnt   <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, stall};
      fwd_cnt   <= fwd_cnt + {30'd0, fwd_inc};
    end
  end

  assign bus.o_stallCnt = stall_cnt;
  assign bus.o_fwdCnt   = fwd_cnt;
`endif
endmodule

// File: tb/tb_pipe_fwd_chain.sv
// tb/tb_pipe_fwd_chain.sv - vector table, corner sequences and random checks for pipe_fwd_chain
module tb_pipe_fwd_chain;
  localparam int XLEN   = 32;
  localparam int STAGES = 3;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  always #5 clk = ~clk;

  pipe_fwd_chain_if #(.XLEN(XLEN), .STAGES(STAGES)) bus ();
  pipe_fwd_chain #(.XLEN(XLEN), .STAGES(STAGES)) dut (.clk(clk), .reset_x(reset_x), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct { bit v; bit [4:0] rd; bit rw; int rdy; } ent_t;
  ent_t hist [STAGES];

  typedef struct {
    bit iv; bit [4:0] ird; bit irw; bit [1:0] irdy;
    bit [4:0] rs1; bit u1; bit [4:0] rs2; bit u2; bit fl;
    bit [31:0] r0; bit [31:0] r1; bit [31:0] r2;
    bit xs; bit [1:0] xsel1; bit [31:0] xd1; bit [1:0] xsel2; bit [31:0] xd2;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < STAGES; a++) hist[a] = '{0, 0, 0, 0};
  endtask

  task automatic model_lookup(input bit [4:0] rs, input bit used, output int sel,
                              output bit [31:0] dat, output bit st);
    bit found = 0;
    sel = 0; dat = 0; st = 0;
    if (used && rs != 0) begin
      for (int a = 0; a < STAGES; a++) begin
        if (!found && hist[a].v && hist[a].rw && hist[a].rd == rs) begin
          found = 1;
          sel = a + 1;
          dat = bus.i_stageResult[a*XLEN +: XLEN];
          st = (a < hist[a].rdy);
        end
      end
    end
  endtask

  task automatic model_check(output bit es);
    int sel1, sel2;
    bit [31:0] d1, d2;
    bit s1, s2;
    model_lookup(bus.i_rs1, bus.i_rs1Used, sel1, d1, s1);
    model_lookup(bus.i_rs2, bus.i_rs2Used, sel2, d2, s2);
    es = (s1 | s2) & bus.i_issueValid & !bus.i_flush;
    chk("stall", 32'(bus.o_stall), 32'(es));
    chk("sel1", 32'(bus.o_fwd1Sel), 32'(sel1));
    chk("data1", bus.o_fwd1Data, d1);
    chk("sel2", 32'(bus.o_fwd2Sel), 32'(sel2));
    chk("data2", bus.o_fwd2Data, d2);
    chk("retire_valid", 32'(bus.o_retireValid), 32'(hist[STAGES-1].v & hist[STAGES-1].rw));
    chk("retire_rd", 32'(bus.o_retireRd), 32'(hist[STAGES-1].rd));
  endtask

  task automatic advance(input bit es);
    bit ld;
    int r;
    ld = bus.i_issueValid && !es && !bus.i_flush;
    r = int'(bus.i_issueReadyStage);
    if (r > STAGES - 1) r = STAGES - 1;
    for (int a = STAGES - 1; a > 0; a--) hist[a] = hist[a-1];
    if (ld) hist[0] = '{1, bus.i_issueRd, bus.i_issueRegWrite, r};
    else    hist[0] = '{0, 0, 0, 0};
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit [4:0] ird, input bit irw, input bit [1:0] irdy,
                       input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2,
                       input bit fl, input bit [31:0] r0, input bit [31:0] r1, input bit [31:0] r2);
    bus.i_issueValid      = iv;
    bus.i_issueRd         = ird;
    bus.i_issueRegWrite   = irw;
    bus.i_issueReadyStage = irdy;
    bus.i_rs1             = rs1;
    bus.i_rs1Used         = u1;
    bus.i_rs2             = rs2;
    bus.i_rs2Used         = u2;
    bus.i_flush           = fl;
    bus.i_stageResult     = {r2, r1, r0};
  endtask

  task automatic cycle();
    bit es;
    @(negedge clk);
    model_check(es);
    advance(es);
  endtask

  initial begin
    bit es;
    tbl[0]  = '{1, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,  5, 1, 0, 0, 0,  32'h1234, 0, 0,              0, 1, 32'h1234, 0, 0};
    tbl[2]  = '{1, 7, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[3]  = '{1, 9, 1, 0,  0, 0, 7, 1, 0,  32'h1111, 32'hDEADBEEF, 0,   1, 0, 0, 1, 32'h1111};
    tbl[4]  = '{1, 9, 1, 0,  0, 0, 7, 1, 0,  32'h1111, 32'hDEADBEEF, 0,   0, 0, 0, 2, 32'hDEADBEEF};
    tbl[5]  = '{1, 3, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[6]  = '{1, 10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[7]  = '{1, 3, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[8]  = '{1, 4, 1, 0,  3, 1, 3, 1, 0,  32'hA, 32'hB, 32'hC,         0, 1, 32'hA, 1, 32'hA};
    tbl[9]  = '{1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0,  0, 1, 4, 0, 0,  32'h5, 32'h6, 32'h7,         0, 0, 0, 0, 0};
    tbl[11] = '{1, 7, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0,                     0, 0, 0, 0, 0};
    tbl[12] = '{1, 12, 1, 0, 0, 0, 7, 1, 1,  32'h55, 0, 0,                0, 0, 0, 1, 32'h55};
    tbl[13] = '{0, 0, 0, 0,  12, 1, 7, 1, 0, 32'h66, 32'h77, 0,           0, 0, 0, 2, 32'h77};

    clear_model();
    drive(1, 3, 1, 0, 3, 1, 3, 1, 0, 32'h11, 32'h22, 32'h33);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(bus.o_stall), 0);
    chk("reset_sel1", 32'(bus.o_fwd1Sel), 0);
    chk("reset_sel2", 32'(bus.o_fwd2Sel), 0);
    chk("reset_retire", 32'(bus.o_retireValid), 0);
    @(posedge clk);
    #1;
    reset_x = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].ird, tbl[i].irw, tbl[i].irdy, tbl[i].rs1, tbl[i].u1,
            tbl[i].rs2, tbl[i].u2, tbl[i].fl, tbl[i].r0, tbl[i].r1, tbl[i].r2);
      @(negedge clk);
      model_check(es);
      chk($sformatf("vec%0d_stall", i), 32'(bus.o_stall), 32'(tbl[i].xs));
      chk($sformatf("vec%0d_sel1", i), 32'(bus.o_fwd1Sel), 32'(tbl[i].xsel1));
      chk($sformatf("vec%0d_data1", i), bus.o_fwd1Data, tbl[i].xd1);
      chk($sformatf("vec%0d_sel2", i), 32'(bus.o_fwd2Sel), 32'(tbl[i].xsel2));
      chk($sformatf("vec%0d_data2", i), bus.o_fwd2Data, tbl[i].xd2);
      advance(es);
    end

    // Ready stage beyond the last tracked stage: clamped, so a match in the last stage forwards.
    drive(1, 20, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 20, 1, 0, 0, 0, 1, 2, 3);
    @(negedge clk);
    chk("clamp_stall_s0", 32'(bus.o_stall), 0);
    model_check(es);
    advance(es);
    drive(1, 21, 1, 0, 20, 1, 0, 0, 0, 1, 2, 3);
    @(negedge clk);
    chk("clamp_stall_s1", 32'(bus.o_stall), 1);
    model_check(es);
    advance(es);
    drive(1, 21, 1, 0, 20, 1, 0, 0, 0, 1, 2, 3);
    @(negedge clk);
    chk("clamp_stall_s2", 32'(bus.o_stall), 0);
    chk("clamp_sel_s2", 32'(bus.o_fwd1Sel), 3);
    chk("clamp_data_s2", bus.o_fwd1Data, 32'h3);
    model_check(es);
    advance(es);

    // Fill the pipe with three writers, then pull reset in mid-cycle.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 3, 1, 1, 1, 0, 32'hAA, 32'hBB, 32'hCC);
    @(negedge clk);
    model_check(es);
    chk("pre_reset_sel2", 32'(bus.o_fwd2Sel), 3);
    #2;
    reset_x = 1'b0;
    #1;
    chk("async_rst_retire", 32'(bus.o_retireValid), 0);
    chk("async_rst_sel1", 32'(bus.o_fwd1Sel), 0);
    chk("async_rst_sel2", 32'(bus.o_fwd2Sel), 0);
    chk("async_rst_data1", bus.o_fwd1Data, 0);
    chk("async_rst_data2", bus.o_fwd2Data, 0);
    chk("async_rst_stall", 32'(bus.o_stall), 0);
`ifdef PIPE_FWD_PERF_CNT_EN
    chk("async_rst_stallcnt", bus.o_stallCnt, 0);
    chk("async_rst_fwdcnt", bus.o_fwdCnt, 0);
`endif
    clear_model();
    @(posedge clk);
    #1;
    reset_x = 1'b1;

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom, $urandom, $urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
